// File: rtl/memory_lookup_pkg.sv
// Shared types and constants for the cache memory lookup reader.
package memory_lookup_pkg;

  typedef enum logic [1:0] {
    LK_IDLE,
    LK_SCAN,
    LK_RESP
  } lookup_state_t;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/memory_lookup_stats.sv
// Saturating hit/miss counters for completed lookup responses.
// Only instantiated when MEMORY_LOOKUP_STATS_EN is defined.
module memory_lookup_stats
  import memory_lookup_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resp_fire,
  input  logic              resp_hit,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam logic [STAT_W-1:0] StatMax = '1;

  logic [STAT_W-1:0] hit_count_q, hit_count_d;
  logic [STAT_W-1:0] miss_count_q, miss_count_d;

  // Count one event per response handshake, holding at the maximum value.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (resp_fire) begin
      if (resp_hit) begin
        if (hit_count_q != StatMax) hit_count_d = hit_count_q + 1'b1;
      end else begin
        if (miss_count_q != StatMax) miss_count_d = miss_count_q + 1'b1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: rtl/memory_lookup_reader.sv
// Read side of the cache memory: accepts one key lookup, scans the register-array entries one per
// cycle (select_op tells the array which entry is being read) and returns hit/index/value over a
// valid/ready handshake. The response register stage adds one cycle between the scan decision and
// resp_valid. Optional statistics counters are enabled with MEMORY_LOOKUP_STATS_EN.
module memory_lookup_reader
  import memory_lookup_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned KEY_W       = 32,
  parameter int unsigned VALUE_W     = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [KEY_W-1:0]               req_key,
  input  logic [NUM_ENTRIES*KEY_W-1:0]   entry_keys,
  input  logic [NUM_ENTRIES*VALUE_W-1:0] entry_values,
  input  logic [NUM_ENTRIES-1:0]         entry_used,
  output logic [NUM_ENTRIES-1:0]         select_op,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_hit,
  output logic [$clog2(NUM_ENTRIES)-1:0] resp_index,
  output logic [VALUE_W-1:0]             resp_value
`ifdef MEMORY_LOOKUP_STATS_EN
  ,
  output logic [STAT_W-1:0]              hit_count,
  output logic [STAT_W-1:0]              miss_count
`endif
);

  localparam int unsigned IdxW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ENTRIES - 1);

  lookup_state_t        state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic                 hit_q, hit_d;
  logic [IdxW-1:0]      index_q, index_d;
  logic [VALUE_W-1:0]   value_q, value_d;
  logic                 valid_q, valid_d;

  logic [KEY_W-1:0]     cur_key;
  logic [VALUE_W-1:0]   cur_value;
  logic                 cur_match;

  // Live compare against the entry currently selected.
  always_comb begin
    cur_key   = entry_keys[32'(idx_q)*KEY_W +: KEY_W];
    cur_value = entry_values[32'(idx_q)*VALUE_W +: VALUE_W];
    cur_match = entry_used[idx_q] && (cur_key == key_q);
  end

  // Next-state: accept, scan lowest index first, then hold the response until taken.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    hit_d   = hit_q;
    index_d = index_q;
    value_d = value_q;
    valid_d = valid_q;
    unique case (state_q)
      LK_IDLE: begin
        if (req_valid) begin
          state_d = LK_SCAN;
          key_d   = req_key;
          idx_d   = '0;
        end
      end
      LK_SCAN: begin
        if (cur_match) begin
          hit_d   = 1'b1;
          index_d = idx_q;
          value_d = cur_value;
          state_d = LK_RESP;
        end else if (idx_q == LastIdx) begin
          hit_d   = 1'b0;
          index_d = '0;
          value_d = '0;
          state_d = LK_RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      LK_RESP: begin
        // First RESP cycle only arms the response register.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (resp_ready) begin
          valid_d = 1'b0;
          state_d = LK_IDLE;
        end
      end
      default: state_d = LK_IDLE;
    endcase
  end

  // State and response registers; reset drops any lookup in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LK_IDLE;
      idx_q   <= '0;
      key_q   <= '0;
      hit_q   <= 1'b0;
      index_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      hit_q   <= hit_d;
      index_q <= index_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign req_ready  = (state_q == LK_IDLE);
  assign select_op  = (state_q == LK_SCAN) ? (NUM_ENTRIES'(1) << idx_q) : '0;
  assign resp_valid = valid_q;
  assign resp_hit   = hit_q;
  assign resp_index = index_q;
  assign resp_value = value_q;

`ifdef MEMORY_LOOKUP_STATS_EN
  memory_lookup_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .resp_fire  (valid_q & resp_ready),
    .resp_hit   (hit_q),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule
